rv32i_dmem_responder: RTL and testbench



---
 rtl/rv32i_dmem_responder_pkg.sv | 19 +
 rtl/rv32i_dmem_responder_sram.sv | 28 ++
 rtl/rv32i_dmem_responder.sv | 121 ++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_dmem_responder_pkg.sv
// rv32i_dmem_responder_pkg: FSM state type and RV32I load/store funct3 encodings for the data-memory responder
package rv32i_dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_ACCESS,
        DMEM_RESP
    } dmem_state_t;

    localparam logic [2:0] RV32I_FUNCT3_LB  = 3'b000;
    localparam logic [2:0] RV32I_FUNCT3_LH  = 3'b001;
    localparam logic [2:0] RV32I_FUNCT3_LW  = 3'b010;
    localparam logic [2:0] RV32I_FUNCT3_LBU = 3'b100;
    localparam logic [2:0] RV32I_FUNCT3_LHU = 3'b101;
    localparam logic [2:0] RV32I_FUNCT3_SB  = 3'b000;
    localparam logic [2:0] RV32I_FUNCT3_SH  = 3'b001;
    localparam logic [2:0] RV32I_FUNCT3_SW  = 3'b010;

endpackage

// File: rtl/rv32i_dmem_responder_sram.sv
// rv32i_dmem_sram: single-port MEM_WORDS x 32 data RAM, byte write enables, registered read
//   clk_i    clock
//   re_i     read strobe; rdata_o updates at the next edge, otherwise holds
//   be_i     per-byte write enable
//   addr_i   word index
//   wdata_i  write data, lanes already positioned
//   rdata_o  registered read data
module rv32i_dmem_sram #(
    parameter int MEM_WORDS = 1024,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++)
            if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        if (re_i) rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: multi-cycle RV32I data-memory responder with lane select, load extension and pipeline stall
//   clk_i / resetn_i      clock, synchronous active-low reset
//   dmem_re_i / dmem_we_i load / store request (level, held while stalled; both set = store)
//   dmem_add_i            byte address
//   dmem_funct3_i         RV32I funct3 of the access
//   dmem_wdata_i          right-aligned store data
//   dmem_rdata_o          extended load data, held until the next load completes
//   stall_o               high for WAIT_STATES+2 cycles per access
//   err_o                 misaligned / out-of-range pulse in RESP, only when DMEM_ACCESS_ERR_EN is defined
module rv32i_dmem_responder
    import rv32i_dmem_responder_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        dmem_re_i,
    input  logic        dmem_we_i,
    input  logic [31:0] dmem_add_i,
    input  logic [2:0]  dmem_funct3_i,
    input  logic [31:0] dmem_wdata_i,
    output logic [31:0] dmem_rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int AW = $clog2(MEM_WORDS);

    dmem_state_t state, state_n;
    logic [3:0]  cnt;
    logic [31:0] add_q, wdata_q, rdata_q, word, ext, st_data;
    logic [2:0]  f3_q;
    logic        st_q, acc, fire, err;
    logic [3:0]  be;
    logic [7:0]  byte_v;
    logic [15:0] half;

    always_comb begin
        state_n = state;
        stall_o = 1'b0;
        acc     = 1'b0;
        case (state)
            DMEM_IDLE: if (dmem_re_i || dmem_we_i) begin
                stall_o = 1'b1;
                acc     = 1'b1;
                state_n = DMEM_ACCESS;
            end
            DMEM_ACCESS: begin
                stall_o = 1'b1;
                if (cnt == 4'd0) state_n = DMEM_RESP;
            end
            default: state_n = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state   <= DMEM_IDLE;
            cnt     <= 4'd0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (acc) cnt <= 4'(WAIT_STATES);
            else if (state == DMEM_ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == DMEM_RESP && !st_q) rdata_q <= ext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) begin
            add_q   <= dmem_add_i;
            f3_q    <= dmem_funct3_i;
            wdata_q <= dmem_wdata_i;
            st_q    <= dmem_we_i;
        end
    end

`ifdef DMEM_ACCESS_ERR_EN
    assign err = (add_q >= 32'(4*MEM_WORDS)) ||
                 ((f3_q == RV32I_FUNCT3_LH || (!st_q && f3_q == RV32I_FUNCT3_LHU)) && add_q[0]) ||
                 (f3_q == RV32I_FUNCT3_LW && add_q[1:0] != 2'b00);
    assign err_o = (state == DMEM_RESP) && err;
`else
    logic unused_add;
    assign unused_add = ^add_q[31:AW+2];
    assign err   = 1'b0;
    assign err_o = 1'b0;
`endif

    // RAM op happens on the final ACCESS edge; a reset at that edge discards it
    assign fire = (state == DMEM_ACCESS) && (cnt == 4'd0) && resetn_i;

    assign byte_v = word[{add_q[1:0], 3'b000} +: 8];
    assign half   = add_q[1] ? word[31:16] : word[15:0];
    assign ext    = err                      ? 32'd0 :
                    f3_q == RV32I_FUNCT3_LB  ? {{24{byte_v[7]}}, byte_v} :
                    f3_q == RV32I_FUNCT3_LBU ? {24'd0, byte_v} :
                    f3_q == RV32I_FUNCT3_LH  ? {{16{half[15]}}, half} :
                    f3_q == RV32I_FUNCT3_LHU ? {16'd0, half} :
                    f3_q == RV32I_FUNCT3_LW  ? word : 32'd0;

    assign be      = f3_q == RV32I_FUNCT3_SB ? 4'b0001 << add_q[1:0] :
                     f3_q == RV32I_FUNCT3_SH ? (add_q[1] ? 4'b1100 : 4'b0011) :
                     f3_q == RV32I_FUNCT3_SW ? 4'b1111 : 4'b0000;
    assign st_data = f3_q == RV32I_FUNCT3_SB ? {4{wdata_q[7:0]}} :
                     f3_q == RV32I_FUNCT3_SH ? {2{wdata_q[15:0]}} : wdata_q;

    // RAM data is only live during the RESP of a load; afterwards the captured copy is shown
    assign dmem_rdata_o = (state == DMEM_RESP && !st_q) ? ext : rdata_q;

    rv32i_dmem_sram #(.MEM_WORDS(MEM_WORDS)) u_sram (
        .clk_i   (clk_i),
        .re_i    (fire && !st_q),
        .be_i    ((fire && st_q && !err) ? be : 4'b0000),
        .addr_i  (add_q[AW+1:2]),
        .wdata_i (st_data),
        .rdata_o (word)
    );

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// tb_rv32i_dmem_responder: directed bench with a byte-level memory model and a per-cycle output compare
module tb_rv32i_dmem_responder;

    localparam int N = 4096;
`ifdef DMEM_ACCESS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn [2];
    logic        re [2], we [2], stall [2], err [2];
    logic [2:0]  f3 [2];
    logic [31:0] add [2], wd [2], rd [2];

    logic [7:0]  mem_m [2][N];
    logic [31:0] hold_m [2];
    logic        exp_stall [2], exp_err [2], chk_en [2];
    logic [31:0] got_rd;
    logic        got_err;
    int          n_stall, checks = 0, failures = 0;

    always #5 clk = ~clk;

    rv32i_dmem_responder #(.MEM_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
        .clk_i(clk), .resetn_i(rstn[0]), .dmem_re_i(re[0]), .dmem_we_i(we[0]),
        .dmem_add_i(add[0]), .dmem_funct3_i(f3[0]), .dmem_wdata_i(wd[0]),
        .dmem_rdata_o(rd[0]), .stall_o(stall[0]), .err_o(err[0]));

    rv32i_dmem_responder #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .resetn_i(rstn[1]), .dmem_re_i(re[1]), .dmem_we_i(we[1]),
        .dmem_add_i(add[1]), .dmem_funct3_i(f3[1]), .dmem_wdata_i(wd[1]),
        .dmem_rdata_o(rd[1]), .stall_o(stall[1]), .err_o(err[1]));

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endfunction

    always @(negedge clk)
        for (int i = 0; i < 2; i++)
            if (chk_en[i]) begin
                chk($sformatf("stall%0d", i), 32'(stall[i]), 32'(exp_stall[i]));
                chk($sformatf("rdata%0d", i), rd[i], hold_m[i]);
                chk($sformatf("err%0d", i), 32'(err[i]), 32'(exp_err[i]));
            end

    function automatic logic mdl_err(logic [2:0] f, logic [31:0] a, logic st);
        logic is_half = (f == 3'd1) || (!st && f == 3'd5);
        return ERR_EN && ((a >= N) || (is_half && a[0]) || (f == 3'd2 && a[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] mdl_load(int i, logic [2:0] f, logic [31:0] a);
        int b = int'(a % N);
        int h = b & ~1;
        int w = b & ~3;
        logic [15:0] hv = {mem_m[i][h+1], mem_m[i][h]};
        case (f)
            3'd0: return 32'($signed(mem_m[i][b]));
            3'd4: return {24'd0, mem_m[i][b]};
            3'd1: return 32'($signed(hv));
            3'd5: return {16'd0, hv};
            3'd2: return {mem_m[i][w+3], mem_m[i][w+2], mem_m[i][w+1], mem_m[i][w]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic mdl_store(int i, logic [2:0] f, logic [31:0] a, logic [31:0] d);
        int b = int'(a % N);
        case (f)
            3'd0: mem_m[i][b] = d[7:0];
            3'd1: for (int k = 0; k < 2; k++) mem_m[i][(b & ~1) + k] = d[8*k +: 8];
            3'd2: for (int k = 0; k < 4; k++) mem_m[i][(b & ~3) + k] = d[8*k +: 8];
            default: ;
        endcase
    endtask

    task automatic step(int i);
        @(negedge clk);
        n_stall += int'(stall[i]);
        @(posedge clk);
        #1;
    endtask

    task automatic access(int i, logic r, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] d, bit hold);
        logic e = mdl_err(f, a, w);
        logic [31:0] v = e ? 32'd0 : mdl_load(i, f, a);
        re[i] = r; we[i] = w; f3[i] = f; add[i] = a; wd[i] = d;
        exp_stall[i] = 1'b1;
        n_stall = 0;
        repeat ((i == 0) ? 3 : 2) step(i);
        exp_stall[i] = 1'b0;
        exp_err[i] = e;
        if (w) begin
            if (!e) mdl_store(i, f, a, d);
        end else hold_m[i] = v;
        @(negedge clk);
        got_rd = rd[i];
        got_err = err[i];
        n_stall += int'(stall[i]);
        @(posedge clk);
        #1;
        exp_err[i] = 1'b0;
        if (!hold) begin re[i] = 1'b0; we[i] = 1'b0; end
    endtask

    logic [2:0]  sw_f3 [3] = '{3'd0, 3'd2, 3'd5};
    logic [31:0] sw_a  [3] = '{32'h4B, 32'h40, 32'h46};
    logic [31:0] sw_v  [3] = '{32'hFFFFFFF0, 32'h8899AABB, 32'h00000102};

    initial begin
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; re[i] = 1'b0; we[i] = 1'b0; f3[i] = 3'd0; add[i] = '0; wd[i] = '0;
            hold_m[i] = '0; exp_stall[i] = 1'b0; exp_err[i] = 1'b0; chk_en[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        chk_en[0] = 1'b1; chk_en[1] = 1'b1;
        step(0);

        access(0, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        chk("t1_sw_stall", n_stall, 3);
        access(0, 1, 0, 3'd2, 32'h10, 0, 0);
        chk("t1_lw_stall", n_stall, 3);
        chk("t1_lw", got_rd, 32'hDEADBEEF);

        access(0, 1, 0, 3'd0, 32'h13, 0, 0); chk("t2_lb", got_rd, 32'hFFFFFFDE);
        access(0, 1, 0, 3'd4, 32'h13, 0, 0); chk("t2_lbu", got_rd, 32'h000000DE);
        access(0, 1, 0, 3'd1, 32'h12, 0, 0); chk("t2_lh", got_rd, 32'hFFFFDEAD);
        access(0, 1, 0, 3'd5, 32'h10, 0, 0); chk("t2_lhu", got_rd, 32'h0000BEEF);

        access(0, 0, 1, 3'd0, 32'h11, 32'hCAFE0055, 0);
        access(0, 1, 0, 3'd2, 32'h10, 0, 0); chk("t3_sb", got_rd, 32'hDEAD55EF);
        access(0, 0, 1, 3'd1, 32'h12, 32'hABCD1234, 0);
        access(0, 1, 0, 3'd2, 32'h10, 0, 0); chk("t3_sh", got_rd, 32'h123455EF);

        access(0, 1, 0, 3'd3, 32'h10, 0, 0); chk("unk_load", got_rd, 32'd0);
        access(0, 0, 1, 3'd3, 32'h10, 32'h0, 0);
        access(0, 1, 0, 3'd2, 32'h10, 0, 0); chk("unk_store", got_rd, 32'h123455EF);
`ifndef DMEM_ACCESS_ERR_EN
        access(0, 1, 0, 3'd2, 32'h1010, 0, 0); chk("wrap", got_rd, 32'h123455EF);
`endif

        access(0, 0, 1, 3'd2, 32'h20, 32'h0BADF00D, 0);
        we[0] = 1'b1; f3[0] = 3'd2; add[0] = 32'h20; wd[0] = 32'hFFFFFFFF;
        exp_stall[0] = 1'b1;
        step(0);
        step(0);
        rstn[0] = 1'b0; we[0] = 1'b0;
        step(0);
        rstn[0] = 1'b1; exp_stall[0] = 1'b0; hold_m[0] = '0;
        @(negedge clk);
        chk("t5_stall_after_rst", 32'(stall[0]), 32'd0);
        @(posedge clk);
        #1;
        access(0, 1, 0, 3'd2, 32'h20, 0, 0); chk("t5_old", got_rd, 32'h0BADF00D);

`ifdef DMEM_ACCESS_ERR_EN
        access(0, 0, 1, 3'd2, 32'h0, 32'h11223344, 0);
        access(0, 1, 0, 3'd2, 32'h22, 0, 0);
        chk("t6_lw_err", 32'(got_err), 32'd1); chk("t6_lw_rd", got_rd, 32'd0); chk("t6_lw_stall", n_stall, 3);
        access(0, 0, 1, 3'd2, 32'h1000, 32'hFFFFFFFF, 0);
        chk("t6_sw_err", 32'(got_err), 32'd1); chk("t6_sw_stall", n_stall, 3);
        access(0, 1, 0, 3'd2, 32'h0, 0, 0);
        chk("t6_ram", got_rd, 32'h11223344); chk("t6_ok_err", 32'(got_err), 32'd0);
`endif

        access(1, 0, 1, 3'd2, 32'h40, 32'h8899AABB, 0);
        access(1, 0, 1, 3'd2, 32'h44, 32'h01020304, 0);
        access(1, 0, 1, 3'd2, 32'h48, 32'hF0E0D0C0, 0);
        access(1, 1, 1, 3'd2, 32'h4C, 32'hCAFEF00D, 0);
        access(1, 1, 0, 3'd2, 32'h4C, 0, 0); chk("t4_rewe", got_rd, 32'hCAFEF00D);
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 3; k++) begin
                access(1, 1, 0, sw_f3[k], sw_a[k], 0, !(s == 2 && k == 2));
                chk($sformatf("t4_s%0d_k%0d", s, k), got_rd, sw_v[k]);
                chk($sformatf("t4_stall_s%0d_k%0d", s, k), n_stall, 2);
            end

        step(0);
        step(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
